// File: rtl/param_alu_bcd_if.sv
// param_alu_bcd_if: operation request/response bundle between a requester and the BCD ALU.
interface param_alu_bcd_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
);
    logic                  start;
    logic                  counter_mode;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [3:0]            op_code;
    logic                  busy;
    logic                  done;
    logic [11:0]           instr_code;
    logic [WIDTH-1:0]      result;
    logic                  c_out;
    logic                  err;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start, counter_mode, a, b, op_code,
        input  busy, done, instr_code, result, c_out, err, bcd
    );
    modport slave (
        input  start, counter_mode, a, b, op_code,
        output busy, done, instr_code, result, c_out, err, bcd
    );
endinterface

// File: rtl/param_alu_bcd.sv
// param_alu_bcd: multi-cycle ALU with sequential double-dabble BCD output and a self-incrementing counter mode.
module param_alu_bcd #(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 3,
    parameter int TICK_DIV = 50_000_000
) (
    input logic             clk,
    input logic             rst_n,
    param_alu_bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;
    localparam int TW = $clog2(TICK_DIV) + 1;
    localparam int CW = $clog2(WIDTH);
    localparam int SW = 4 * DIGITS + WIDTH;

    state_t             state, nxt;
    logic [TW-1:0]      tick;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q, b_q, res_h, alu_r;
    logic [3:0]         op_q;
    logic               c_h, err_h, alu_c, ill, launch;
    logic [11:0]        ic_h;
    logic [SW-1:0]      sr, adj;

    assign bus.busy = state != IDLE;
    assign ill      = op_q > 4'd11;
    assign launch   = bus.counter_mode ? tick == TW'(TICK_DIV - 1) : bus.start;

    always_comb begin
        nxt = state == IDLE ? (launch ? EXEC : IDLE) :
              state == EXEC ? CONV :
              state == CONV ? (cnt == CW'(WIDTH - 1) ? DONE : CONV) : IDLE;
    end

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        case (op_q)
            4'd0:  {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
            4'd1:  begin alu_r = a_q - b_q; alu_c = a_q < b_q; end
            4'd2:  alu_r = a_q & b_q;
            4'd3:  alu_r = a_q | b_q;
            4'd4:  alu_r = a_q ^ b_q;
            4'd5:  alu_r = ~a_q;
            4'd6:  begin alu_r = a_q << 1; alu_c = a_q[WIDTH-1]; end
            4'd7:  begin alu_r = a_q >> 1; alu_c = a_q[0]; end
            4'd8:  {alu_c, alu_r} = {1'b0, a_q} + (WIDTH + 1)'(1);
            4'd9:  begin alu_r = a_q - WIDTH'(1); alu_c = a_q == '0; end
            4'd10: begin alu_r = WIDTH'(a_q == b_q); alu_c = a_q < b_q; end
            4'd11: alu_r = b_q;
            default: ;
        endcase
    end

    // Double-dabble correction: bump every BCD digit >= 5 before the shift.
    always_comb begin
        adj = sr;
        for (int i = 0; i < DIGITS; i++)
            if (sr[WIDTH+4*i +: 4] >= 4'd5) adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tick           <= '0;
            cnt            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            res_h          <= '0;
            c_h            <= 1'b0;
            err_h          <= 1'b0;
            ic_h           <= '0;
            sr             <= '0;
            bus.done       <= 1'b0;
            bus.result     <= '0;
            bus.c_out      <= 1'b0;
            bus.err        <= 1'b0;
            bus.instr_code <= '0;
            bus.bcd        <= '0;
        end else begin
            state    <= nxt;
            bus.done <= 1'b0;
            tick     <= (state == IDLE && bus.counter_mode && !launch) ? tick + TW'(1) : '0;
            if (state == IDLE && launch) begin
                a_q  <= bus.counter_mode ? bus.result : bus.a;
                b_q  <= bus.b;
                op_q <= bus.counter_mode ? 4'd8 : bus.op_code;
            end else if (state == EXEC) begin
                res_h <= alu_r;
                c_h   <= alu_c;
                err_h <= ill;
                ic_h  <= ill ? 12'd0 : 12'd1 << op_q;
                sr    <= SW'(alu_r);
                cnt   <= '0;
            end else if (state == CONV) begin
                sr  <= adj << 1;
                cnt <= cnt + CW'(1);
            end else if (state == DONE) begin
                bus.result     <= res_h;
                bus.c_out      <= c_h;
                bus.err        <= err_h;
                bus.instr_code <= ic_h;
                bus.bcd        <= sr[SW-1:WIDTH];
                bus.done       <= 1'b1;
            end
        end
    end
endmodule
